// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: definitions shared by the host-side packet sender and the
// far-side command FSM (frame header, command codes, FSM encoding, checksum).
package uart_pkt_pkg;

    // Header byte that opens every frame
    localparam logic [7:0] SYNC_BYTE = 8'h55;

    // Command codes understood by the far-side command FSM
    localparam logic [7:0] CMD_WRITE = 8'h01;

    // Sender FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    // Frame checksum: 8-bit sum of command and data, carry discarded
    function automatic logic [7:0] chksum8(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] sum;
        sum = cmd + data;
        return sum;
    endfunction

endpackage

// File: rtl/uart_pkt_sender_if.sv
// uart_pkt_sender_if: request handshake, byte-engine and response signals
// of the packet sender. 'master' is the sender's view, 'slave' is the view
// of the surrounding logic (request source, tx/rx byte engines).
interface uart_pkt_sender_if;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cmd;
    logic [7:0] req_data;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] rx_data;
    logic       rx_done;

    logic       pkt_done;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_timeout;

    modport master (
        input  req_valid, req_cmd, req_data,
        input  tx_busy, tx_done,
        input  rx_data, rx_done,
        output req_ready,
        output tx_data, tx_start,
        output pkt_done, resp_valid, resp_data, resp_timeout
    );

    modport slave (
        output req_valid, req_cmd, req_data,
        output tx_busy, tx_done,
        output rx_data, rx_done,
        input  req_ready,
        input  tx_data, tx_start,
        input  pkt_done, resp_valid, resp_data, resp_timeout
    );

endinterface

// File: rtl/uart_pkt_timeout.sv
// uart_pkt_timeout: response wait timer. Held at zero while clr_i is high,
// counts while en_i is high, and flags expired_o in the cycle the count
// reaches CYCLES-1. The count saturates there; the owner leaves its wait
// state on expiry, so expired_o is seen as a single-cycle pulse.
module uart_pkt_timeout #(
    parameter int unsigned CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance until the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_pkt_sender.sv
// uart_pkt_sender: serialises {SYNC, CMD, DATA, CHKSUM} through the byte
// UART transmitter and, when UART_PKT_RESP_WAIT_EN is defined, waits for a
// single response byte with a timeout. Without UART_PKT_RESP_WAIT_EN the
// response outputs are tied to zero and rx_data/rx_done are unused.
module uart_pkt_sender #(
    parameter logic [7:0]  SYNC_BYTE           = uart_pkt_pkg::SYNC_BYTE,
    parameter int unsigned RESP_TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_pkt_sender_if.master bus
);

    import uart_pkt_pkg::*;

    state_e     state_q;
    logic [1:0] idx_q;
    logic [7:0] cmd_q;
    logic [7:0] data_q;
    logic [7:0] chk_q;
    logic       req_ready_q;
    logic       tx_start_q;
    logic [7:0] tx_data_q;
    logic       pkt_done_q;
    logic [7:0] tx_byte_d;

`ifdef UART_PKT_RESP_WAIT_EN
    logic       resp_valid_q;
    logic       resp_timeout_q;
    logic [7:0] resp_data_q;
    logic       tmr_clr;
    logic       tmr_en;
    logic       tmr_expired;

    // Timer runs only while in RESP and restarts from zero on every entry
    assign tmr_clr = (state_q != ST_RESP);
    assign tmr_en  = (state_q == ST_RESP);

    uart_pkt_timeout #(
        .CYCLES (RESP_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );
`endif

    // Frame byte selected by the current index
    always_comb begin
        tx_byte_d = chk_q;
        case (idx_q)
            2'd0:    tx_byte_d = SYNC_BYTE;
            2'd1:    tx_byte_d = cmd_q;
            2'd2:    tx_byte_d = data_q;
            default: tx_byte_d = chk_q;
        endcase
    end

    // Packet FSM with registered outputs; pulse outputs default low each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            chk_q       <= '0;
            req_ready_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            pkt_done_q  <= 1'b0;
`ifdef UART_PKT_RESP_WAIT_EN
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_data_q    <= '0;
`endif
        end else begin
            tx_start_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            req_ready_q <= 1'b0;
`ifdef UART_PKT_RESP_WAIT_EN
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // Ready is registered, so it rises one cycle into IDLE
                    if (bus.req_valid && req_ready_q) begin
                        cmd_q   <= bus.req_cmd;
                        data_q  <= bus.req_data;
                        chk_q   <= chksum8(bus.req_cmd, bus.req_data);
                        idx_q   <= '0;
                        state_q <= ST_LOAD;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!bus.tx_busy) begin
                        tx_data_q  <= tx_byte_d;
                        tx_start_q <= 1'b1;
                        state_q    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.tx_done) begin
                        if (idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= ST_LOAD;
                        end else begin
                            pkt_done_q <= 1'b1;
`ifdef UART_PKT_RESP_WAIT_EN
                            state_q    <= ST_RESP;
`else
                            state_q    <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef UART_PKT_RESP_WAIT_EN
                ST_RESP: begin
                    // A byte arriving on the expiry cycle still counts as a response
                    if (bus.rx_done) begin
                        resp_data_q  <= bus.rx_data;
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else if (tmr_expired) begin
                        resp_timeout_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.pkt_done  = pkt_done_q;

`ifdef UART_PKT_RESP_WAIT_EN
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_timeout = resp_timeout_q;
`else
    logic unused_resp_inputs;
    assign unused_resp_inputs = ^{bus.rx_data, bus.rx_done, RESP_TIMEOUT_CYCLES[0]};

    assign bus.resp_valid   = 1'b0;
    assign bus.resp_data    = '0;
    assign bus.resp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_pkt_sender.sv
// tb_uart_pkt_sender: directed bench for uart_pkt_sender with a 10-cycle
// busy transmitter model. Response tests apply when UART_PKT_RESP_WAIT_EN
// is defined.
module tb_uart_pkt_sender;

    import uart_pkt_pkg::*;

    localparam int unsigned TMO  = 16;
    localparam int unsigned BUSY = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hold_busy = 1'b0;
    logic gap_chk   = 1'b0;

    always #5 clk = ~clk;

    uart_pkt_sender_if bus ();

    uart_pkt_sender #(
        .SYNC_BYTE           (8'h55),
        .RESP_TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Transmitter model and monitor state
    int unsigned mdl_cnt = 0;
    logic [7:0]  cur_byte = 8'h00;
    int          stable_err = 0;
    logic [7:0]  sent [0:63];
    int unsigned n_sent = 0;
    int unsigned n_pkt = 0;
    int unsigned n_txdone = 0;
    int unsigned n_hs = 0;
    int unsigned n_rv = 0;
    int unsigned n_rto = 0;
    int          cyc = 0;
    int          last_done_cyc = -1;
    int          gap_err = 0;
    int          pkt_gap_err = 0;

    assign bus.tx_busy = (mdl_cnt != 0) || hold_busy;

    // Byte transmitter: BUSY cycles per byte, then a one-cycle tx_done
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt     <= 0;
            bus.tx_done <= 1'b0;
        end else begin
            bus.tx_done <= 1'b0;
            if (mdl_cnt != 0) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) bus.tx_done <= 1'b1;
                if (bus.tx_data !== cur_byte) stable_err <= stable_err + 1;
            end else if (bus.tx_start === 1'b1) begin
                mdl_cnt  <= BUSY;
                cur_byte <= bus.tx_data;
            end
        end
    end

    // Event monitor: byte log, pulse counts and inter-event spacing
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready === 1'b1) n_hs <= n_hs + 1;
        if (bus.tx_start === 1'b1) begin
            sent[n_sent % 64] <= bus.tx_data;
            n_sent <= n_sent + 1;
            if (gap_chk && last_done_cyc >= 0 && (cyc - last_done_cyc) != 2) gap_err <= gap_err + 1;
        end
        if (bus.tx_done === 1'b1) begin
            n_txdone      <= n_txdone + 1;
            last_done_cyc <= cyc;
        end
        if (bus.pkt_done === 1'b1) begin
            n_pkt <= n_pkt + 1;
            if ((cyc - last_done_cyc) != 1) pkt_gap_err <= pkt_gap_err + 1;
            last_done_cyc <= -1;
        end
        if (bus.resp_valid === 1'b1)   n_rv  <= n_rv + 1;
        if (bus.resp_timeout === 1'b1) n_rto <= n_rto + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [7:0] c, input logic [7:0] d);
        int k;
        k = 0;
        bus.req_cmd   = c;
        bus.req_data  = d;
        bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && k < 500) begin
            tick(1);
            k++;
        end
        if (k >= 500) check("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_pkt(input string tag);
        int k;
        k = 0;
        while (bus.pkt_done !== 1'b1 && k < 2000) begin
            tick(1);
            k++;
        end
        check({tag, "_pkt_done"}, {31'd0, bus.pkt_done}, 32'd1);
    endtask

    task automatic check_frame(input string tag, input int unsigned base,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        check({tag, "_b0"}, {24'd0, sent[(base + 0) % 64]}, {24'd0, b0});
        check({tag, "_b1"}, {24'd0, sent[(base + 1) % 64]}, {24'd0, b1});
        check({tag, "_b2"}, {24'd0, sent[(base + 2) % 64]}, {24'd0, b2});
        check({tag, "_b3"}, {24'd0, sent[(base + 3) % 64]}, {24'd0, b3});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},    {31'd0, bus.req_ready},    32'd0);
        check({tag, "_tx_start"},     {31'd0, bus.tx_start},     32'd0);
        check({tag, "_tx_data"},      {24'd0, bus.tx_data},      32'd0);
        check({tag, "_pkt_done"},     {31'd0, bus.pkt_done},     32'd0);
        check({tag, "_resp_valid"},   {31'd0, bus.resp_valid},   32'd0);
        check({tag, "_resp_data"},    {24'd0, bus.resp_data},    32'd0);
        check({tag, "_resp_timeout"}, {31'd0, bus.resp_timeout}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned base;
        int unsigned p0;
        int unsigned h0;
        int unsigned t0;
        int unsigned k;
        int unsigned rv0;
        int unsigned rto0;

        bus.req_valid = 1'b0;
        bus.req_cmd   = 8'h00;
        bus.req_data  = 8'h00;
        bus.rx_data   = 8'h00;
        bus.rx_done   = 1'b0;

        // Reset values, then ready rises one cycle after release
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        check("rst_rel_ready_low", {31'd0, bus.req_ready}, 32'd0);
        tick(1);
        check("rst_rel_ready_high", {31'd0, bus.req_ready}, 32'd1);

        // Basic frame with latency, pulse width and spacing checks
        base = n_sent;
        p0 = n_pkt;
        gap_chk = 1'b1;
        bus.req_cmd   = CMD_WRITE;
        bus.req_data  = 8'hA5;
        bus.req_valid = 1'b1;
        tick(1);
        bus.req_valid = 1'b0;
        check("lat_start_lo", {31'd0, bus.tx_start}, 32'd0);
        check("lat_ready_lo", {31'd0, bus.req_ready}, 32'd0);
        tick(1);
        check("lat_start_hi", {31'd0, bus.tx_start}, 32'd1);
        check("lat_data_sync", {24'd0, bus.tx_data}, {24'd0, SYNC_BYTE});
        tick(1);
        check("start_width", {31'd0, bus.tx_start}, 32'd0);
        check("data_hold", {24'd0, bus.tx_data}, 32'h55);
        wait_pkt("basic");
        tick(1);
`ifdef UART_PKT_RESP_WAIT_EN
        check("basic_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
`else
        check("basic_ready_back", {31'd0, bus.req_ready}, 32'd1);
`endif
        gap_chk = 1'b0;
        check_frame("basic", base, 8'h55, 8'h01, 8'hA5, 8'hA6);
        check("basic_nstart", n_sent - base, 32'd4);
        check("basic_npkt", n_pkt - p0, 32'd1);
        check("done_to_start_gap", gap_err, 32'd0);
        check("done_to_pkt_gap", pkt_gap_err, 32'd0);
        check("tx_data_stable", stable_err, 32'd0);

`ifndef UART_PKT_RESP_WAIT_EN
        // Response path compiled out: rx activity has no effect
        bus.rx_data = 8'h5A;
        bus.rx_done = 1'b1;
        tick(1);
        bus.rx_done = 1'b0;
        check("noresp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("noresp_data", {24'd0, bus.resp_data}, 32'd0);
        tick(1);
        check("noresp_valid2", {31'd0, bus.resp_valid}, 32'd0);
`endif

        // Checksum wraps modulo 256
        base = n_sent;
        send_req(8'hF0, 8'h20);
        wait_pkt("wrap");
        tick(1);
        check_frame("wrap", base, 8'h55, 8'hF0, 8'h20, 8'h10);

`ifdef UART_PKT_RESP_WAIT_EN
        // Response captured 5 cycles after pkt_done
        send_req(8'h12, 8'h34);
        wait_pkt("resp");
        rv0 = n_rv;
        rto0 = n_rto;
        tick(5);
        bus.rx_data = 8'h5A;
        bus.rx_done = 1'b1;
        tick(1);
        bus.rx_done = 1'b0;
        check("resp_valid_hi", {31'd0, bus.resp_valid}, 32'd1);
        check("resp_data", {24'd0, bus.resp_data}, 32'h5A);
        tick(1);
        check("resp_valid_lo", {31'd0, bus.resp_valid}, 32'd0);
        check("resp_data_hold", {24'd0, bus.resp_data}, 32'h5A);
        tick(20);
        check("resp_nvalid", n_rv - rv0, 32'd1);
        check("resp_no_timeout", n_rto - rto0, 32'd0);

        // Timeout pulse 16 cycles after pkt_done
        send_req(8'h21, 8'h43);
        wait_pkt("tmo");
        rto0 = n_rto;
        tick(15);
        check("tmo_early", {31'd0, bus.resp_timeout}, 32'd0);
        tick(1);
        check("tmo_pulse", {31'd0, bus.resp_timeout}, 32'd1);
        check("tmo_ready_lo", {31'd0, bus.req_ready}, 32'd0);
        tick(1);
        check("tmo_width", {31'd0, bus.resp_timeout}, 32'd0);
        check("tmo_ready_hi", {31'd0, bus.req_ready}, 32'd1);
        tick(20);
        check("tmo_count", n_rto - rto0, 32'd1);

        // rx_done on the expiry cycle wins over the timeout
        send_req(8'h30, 8'h40);
        wait_pkt("coinc");
        rv0 = n_rv;
        rto0 = n_rto;
        tick(15);
        bus.rx_data = 8'hC3;
        bus.rx_done = 1'b1;
        tick(1);
        bus.rx_done = 1'b0;
        check("coinc_valid", {31'd0, bus.resp_valid}, 32'd1);
        check("coinc_no_tmo", {31'd0, bus.resp_timeout}, 32'd0);
        check("coinc_data", {24'd0, bus.resp_data}, 32'hC3);
        tick(20);
        check("coinc_nvalid", n_rv - rv0, 32'd1);
        check("coinc_ntmo", n_rto - rto0, 32'd0);

        // rx_done in IDLE is ignored
        bus.rx_data = 8'h77;
        bus.rx_done = 1'b1;
        tick(1);
        bus.rx_done = 1'b0;
        check("idle_rx_ignored_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("idle_rx_ignored_data", {24'd0, bus.resp_data}, 32'hC3);
`endif

        // Backpressure at LOAD plus a second request held during the frame
        base = n_sent;
        p0 = n_pkt;
        h0 = n_hs;
        hold_busy = 1'b1;
        send_req(8'h11, 8'h22);
        bus.req_cmd   = 8'h33;
        bus.req_data  = 8'h44;
        bus.req_valid = 1'b1;
        tick(50);
        check("bp_no_start", n_sent - base, 32'd0);
        check("bp_start_lo", {31'd0, bus.tx_start}, 32'd0);
        check("bp_ready_lo", {31'd0, bus.req_ready}, 32'd0);
        hold_busy = 1'b0;
        k = 0;
        while (n_hs != h0 + 2 && k < 2000) begin
            tick(1);
            k++;
        end
        bus.req_valid = 1'b0;
        check("bp_hs2", n_hs - h0, 32'd2);
        wait_pkt("bp2");
        tick(1);
        check_frame("bp_f1", base, 8'h55, 8'h11, 8'h22, 8'h33);
        check_frame("bp_f2", base + 4, 8'h55, 8'h33, 8'h44, 8'h77);
        check("bp_nstart", n_sent - base, 32'd8);
        check("bp_npkt", n_pkt - p0, 32'd2);

        // Reset after the 2nd tx_done of a frame
        base = n_sent;
        t0 = n_txdone;
        send_req(8'hAA, 8'h0F);
        k = 0;
        while (n_txdone != t0 + 2 && k < 2000) begin
            tick(1);
            k++;
        end
        check("mid_txdone_seen", n_txdone - t0, 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick(2);
        check("mid_partial_bytes", n_sent - base, 32'd2);
        rst_n = 1'b1;
        base = n_sent;
        p0 = n_pkt;
        send_req(8'h02, 8'h03);
        wait_pkt("after_rst");
        tick(1);
        check_frame("after_rst", base, 8'h55, 8'h02, 8'h03, 8'h05);
        check("after_rst_nstart", n_sent - base, 32'd4);
        check("after_rst_npkt", n_pkt - p0, 32'd1);

        tick(TMO + 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
